// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, models multi-cycle latency with a
// busy counter and requests a D-stage stall while the unit is occupied.
module e_mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDUOp,
   input  logic [31:0] E_RS,
   input  logic [31:0] E_RT,
   input  logic        E_Cancel,
   input  logic        D_MDUUse,
   output logic        E_Start,
   output logic        E_Busy,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO,
   output logic [31:0] E_MDUOut,
   output logic        D_MDUStall
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {S_IDLE, S_BUSY} state_e;

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic [31:0]   w_hi_nxt, w_lo_nxt, w_pend_hi_nxt, w_pend_lo_nxt;
   logic [31:0]   w_res_hi, w_res_lo;
   logic          w_busy, w_is_mul, w_is_div;

   logic [63:0]   w_prod_s, w_prod_u;
   logic          w_div_zero, w_div_ovf;
   logic [31:0]   w_div_rt, w_quo_s, w_rem_s, w_quo_u, w_rem_u;

   assign w_busy   = (r_cnt != '0);
   assign w_is_mul = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
   assign w_is_div = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);

   assign w_prod_s = $signed({{32{E_RS[31]}}, E_RS}) * $signed({{32{E_RT[31]}}, E_RT});
   assign w_prod_u = {32'b0, E_RS} * {32'b0, E_RT};

   // Special divides are resolved by mux; the divider sees a safe divisor so it never traps.
   assign w_div_zero = (E_RT == '0);
   assign w_div_ovf  = (E_RS == 32'h8000_0000) && (E_RT == 32'hFFFF_FFFF);
   assign w_div_rt   = (w_div_zero || w_div_ovf) ? 32'd1 : E_RT;
   assign w_quo_s    = $signed(E_RS) / $signed(w_div_rt);
   assign w_rem_s    = $signed(E_RS) % $signed(w_div_rt);
   assign w_quo_u    = E_RS / w_div_rt;
   assign w_rem_u    = E_RS % w_div_rt;

   always_comb begin
      w_res_hi = '0;
      w_res_lo = '0;
      case (E_MDUOp)
         OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
         OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
         OP_DIV: begin
            if (w_div_zero) begin
               w_res_hi = E_RS;
               w_res_lo = 32'hFFFF_FFFF;
            end else if (w_div_ovf) begin
               w_res_hi = '0;
               w_res_lo = 32'h8000_0000;
            end else begin
               w_res_hi = w_rem_s;
               w_res_lo = w_quo_s;
            end
         end
         OP_DIVU: begin
            w_res_hi = w_div_zero ? E_RS : w_rem_u;
            w_res_lo = w_div_zero ? 32'hFFFF_FFFF : w_quo_u;
         end
         default: ;
      endcase
   end

   assign E_Start    = (w_is_mul || w_is_div) && !E_Cancel && !w_busy;
   assign E_Busy     = w_busy;
   assign E_HI       = r_hi;
   assign E_LO       = r_lo;
   assign D_MDUStall = D_MDUUse && (E_Start || w_busy);

   always_comb begin
      E_MDUOut = '0;
      if (E_MDUOp == OP_MFHI)      E_MDUOut = r_hi;
      else if (E_MDUOp == OP_MFLO) E_MDUOut = r_lo;
   end

   // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_pend_hi_nxt = r_pend_hi;
      w_pend_lo_nxt = r_pend_lo;
      case (r_state)
         S_IDLE: begin
            if (E_Start) begin
               w_pend_hi_nxt = w_res_hi;
               w_pend_lo_nxt = w_res_lo;
               w_cnt_nxt     = w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               w_state_nxt   = S_BUSY;
            end else if (!E_Cancel && E_MDUOp == OP_MTHI) begin
               w_hi_nxt = E_RS;
            end else if (!E_Cancel && E_MDUOp == OP_MTLO) begin
               w_lo_nxt = E_RS;
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_hi_nxt    = r_pend_hi;
               w_lo_nxt    = r_pend_lo;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
      end
   end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: directed ops; expected HI/LO/latency go into a queue that a
// monitor drains whenever E_Busy falls.
module tb_e_mdu_ctrl;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [3:0]  E_MDUOp;
   logic [31:0] E_RS, E_RT;
   logic        E_Cancel, D_MDUUse;
   logic        E_Start, E_Busy, D_MDUStall;
   logic [31:0] E_HI, E_LO, E_MDUOut;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .E_MDUOp    (E_MDUOp),
      .E_RS       (E_RS),
      .E_RT       (E_RT),
      .E_Cancel   (E_Cancel),
      .D_MDUUse   (D_MDUUse),
      .E_Start    (E_Start),
      .E_Busy     (E_Busy),
      .E_HI       (E_HI),
      .E_LO       (E_LO),
      .E_MDUOut   (E_MDUOut),
      .D_MDUStall (D_MDUStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a falling E_Busy is a completed (or reset-aborted) operation.
   int   busy_run  = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (E_Busy === 1'b1) begin
         busy_run++;
      end else if (prev_busy) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_done: got HI=%h LO=%h expected no completion", E_HI, E_LO);
         end else begin
            e = sb_q.pop_front();
            check({e.name, "_cycles"}, busy_run, e.cycles);
            check({e.name, "_hi"}, E_HI, e.hi);
            check({e.name, "_lo"}, E_LO, e.lo);
         end
         busy_run = 0;
      end
      prev_busy = (E_Busy === 1'b1);
   end

   task automatic wait_idle();
      for (int i = 0; i < 40 && E_Busy !== 1'b0; i++) @(negedge clk);
      check("wait_idle_busy", E_Busy, 1'b0);
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                         input int cyc, input logic use_d);
      exp_t e;
      @(posedge clk); #1;
      E_MDUOp = op; E_RS = rs; E_RT = rt; E_Cancel = 1'b0; D_MDUUse = use_d;
      e.name = name; e.hi = ehi; e.lo = elo; e.cycles = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      check({name, "_start"}, E_Start, 1'b1);
      check({name, "_stall_start"}, D_MDUStall, use_d);
      @(posedge clk); #1;
      E_MDUOp = OP_NONE;
      for (int i = 0; i < cyc; i++) begin
         @(negedge clk);
         check({name, "_busy"}, E_Busy, 1'b1);
         check({name, "_stall_busy"}, D_MDUStall, use_d);
      end
      @(negedge clk);
      check({name, "_busy_end"}, E_Busy, 1'b0);
      check({name, "_stall_end"}, D_MDUStall, 1'b0);
      wait_idle();
      m_hi = ehi;
      m_lo = elo;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      // Reset with garbage inputs for two edges.
      reset = 1'b0; E_MDUOp = OP_MULT; E_RS = 32'hDEAD_BEEF; E_RT = 32'h1234_5678;
      E_Cancel = 1'b0; D_MDUUse = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1; E_MDUOp = OP_NONE; E_RS = '0; E_RT = '0;
      @(negedge clk);
      check("rst_hi", E_HI, 32'h0);
      check("rst_lo", E_LO, 32'h0);
      check("rst_busy", E_Busy, 1'b0);
      check("rst_start", E_Start, 1'b0);
      check("rst_stall", D_MDUStall, 1'b0);
      D_MDUUse = 1'b0;

      // Arithmetic, with the stall observed both with and without D_MDUUse.
      run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, 1'b1);
      run_op("multu",     OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 5, 1'b0);
      run_op("divu",      OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0);
      run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1);
      run_op("div_negd",  OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1'b0);
      run_op("div_zero",  OP_DIV,   32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 10, 1'b0);
      run_op("divu_zero", OP_DIVU,  32'hDEAD, 32'd0, 32'hDEAD, 32'hFFFF_FFFF, 10, 1'b0);
      run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, 1'b0);

      // Cancel suppresses starts and mt* writes; mthi/mfhi/mflo without cancel.
      @(posedge clk); #1;
      E_MDUOp = OP_DIV; E_RS = 32'd100; E_RT = 32'd7; E_Cancel = 1'b1;
      @(negedge clk);
      check("cancel_start", E_Start, 1'b0);
      @(posedge clk); #1;
      E_MDUOp = OP_MTLO; E_RS = 32'hABCD;
      @(negedge clk);
      check("cancel_busy", E_Busy, 1'b0);
      check("cancel_hi", E_HI, m_hi);
      @(posedge clk); #1;
      E_MDUOp = OP_MTHI; E_RS = 32'h55; E_Cancel = 1'b0;
      @(negedge clk);
      check("cancel_mtlo_lo", E_LO, m_lo);
      @(posedge clk); #1;
      E_MDUOp = OP_MFHI;
      @(negedge clk);
      check("mthi_hi", E_HI, 32'h55);
      check("mfhi_out", E_MDUOut, 32'h55);
      check("mthi_busy", E_Busy, 1'b0);
      m_hi = 32'h55;
      @(posedge clk); #1;
      E_MDUOp = OP_MFLO;
      @(negedge clk);
      check("mflo_out", E_MDUOut, m_lo);
      @(posedge clk); #1;
      E_MDUOp = OP_MTLO; E_RS = 32'h1357;
      @(negedge clk);
      check("mtlo_out_none", E_MDUOut, 32'h0);
      @(posedge clk); #1;
      E_MDUOp = 4'd12;
      @(negedge clk);
      check("mtlo_lo", E_LO, 32'h1357);
      check("badop_out", E_MDUOut, 32'h0);
      check("badop_start", E_Start, 1'b0);
      m_lo = 32'h1357;

      // Collisions while busy: divu and mthi ignored, cancel does not kill a running op.
      @(posedge clk); #1;
      E_MDUOp = OP_MULT; E_RS = 32'd6; E_RT = 32'd7; E_Cancel = 1'b0;
      e.name = "mult_coll"; e.hi = 32'h0; e.lo = 32'd42; e.cycles = 5;
      sb_q.push_back(e);
      @(negedge clk);
      check("coll_start", E_Start, 1'b1);
      @(posedge clk); #1;
      E_MDUOp = OP_DIVU; E_RS = 32'd100; E_RT = 32'd7;
      @(negedge clk);
      check("coll_divu_start", E_Start, 1'b0);
      check("coll_divu_busy", E_Busy, 1'b1);
      @(posedge clk); #1;
      E_MDUOp = OP_MTHI; E_RS = 32'h99;
      @(posedge clk); #1;
      E_MDUOp = OP_NONE; E_Cancel = 1'b1;
      @(negedge clk);
      check("coll_mthi_hi", E_HI, m_hi);
      @(posedge clk); #1;
      E_Cancel = 1'b0;
      wait_idle();
      @(negedge clk);
      check("coll_hi_after", E_HI, 32'h0);
      check("coll_lo_after", E_LO, 32'd42);

      // Reset in the middle of a divide discards it and clears HI/LO.
      @(posedge clk); #1;
      E_MDUOp = OP_DIVU; E_RS = 32'd50; E_RT = 32'd5;
      e.name = "rst_abort"; e.hi = 32'h0; e.lo = 32'h0; e.cycles = 3;
      sb_q.push_back(e);
      @(negedge clk);
      check("abort_start", E_Start, 1'b1);
      @(posedge clk); #1;
      E_MDUOp = OP_NONE;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", E_Busy, 1'b0);
      check("abort_hi", E_HI, 32'h0);
      check("abort_lo", E_LO, 32'h0);
      reset = 1'b1;

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
